control_seq: RTL

- Parametrised multi-cycle control sequencer for the datapath: fetch, decode, execute.
- Drives PC, IR, register file, ALU, MAR/MDR and memory strobes. Decodes ALU, LD, ST, LI, JZ, JNZ and SYS classes.
- Adds a variable-latency memory handshake with a bus-timeout watchdog, halt/illegal reporting, and a sticky halted state.

---
 rtl/control_seq_pkg.sv | 43 ++++
 rtl/control_seq_if.sv | 44 ++++
 rtl/control_seq_mem_wait_timer.sv | 43 ++++
 rtl/control_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/control_seq_pkg.sv
// control_pkg: shared constants for the control sequencer.
//   - opcode values of the fixed-function instruction classes
//   - 5-bit binary state encoding
//   - select encodings for write-back, memory address and MDR source
package control_pkg;

    localparam logic [3:0] OP_SYS = 4'd0;
    localparam logic [3:0] OP_LD  = 4'd8;
    localparam logic [3:0] OP_ST  = 4'd9;
    localparam logic [3:0] OP_LI  = 4'd10;
    localparam logic [3:0] OP_JZ  = 4'd11;
    localparam logic [3:0] OP_JNZ = 4'd12;

    typedef enum logic [4:0] {
        RST_PC  = 5'd0,
        FETCH   = 5'd1,
        DECODE  = 5'd2,
        ALU_A   = 5'd3,
        ALU_B   = 5'd4,
        ALU_WB  = 5'd5,
        LD_ADDR = 5'd6,
        LD_MEM  = 5'd7,
        LD_WB   = 5'd8,
        ST_ADDR = 5'd9,
        ST_DATA = 5'd10,
        ST_MEM  = 5'd11,
        LI_INC  = 5'd12,
        LI_MEM  = 5'd13,
        LI_WB   = 5'd14,
        J_TEST  = 5'd15,
        J_LOAD  = 5'd16,
        INCPC   = 5'd17,
        HALT    = 5'd18
    } state_t;

    localparam logic WB_ALU   = 1'b0;
    localparam logic WB_MDR   = 1'b1;
    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_MAR = 1'b1;
    localparam logic MDR_MEM  = 1'b0;
    localparam logic MDR_REG  = 1'b1;

endpackage

// File: rtl/control_seq_if.sv
// control_seq_if: bundle between the sequencer and the datapath/memory.
//   master : sequencer side (drives strobes/selects, reads ir, rdata_zero, mem_ready)
//   slave  : datapath/memory side
interface control_seq_if #(
    parameter int WIDTH   = 16,
    parameter int REGADDR = 6
);
    logic [WIDTH-1:0]   ir;
    logic               rdata_zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               mem_addr_sel;
    logic               mdr_load;
    logic               mdr_sel;
    logic               ir_load;
    logic               mar_load;
    logic               pc_clr;
    logic               pc_inc;
    logic               pc_load;
    logic [REGADDR-1:0] reg_addr;
    logic               reg_we;
    logic               wb_sel;
    logic [2:0]         alu_op;
    logic               alu_a_load;
    logic               alu_y_load;
    logic               halted;
    logic               illegal;
    logic               bus_err;

    modport master (
        input  ir, rdata_zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, mdr_load, mdr_sel, ir_load,
               mar_load, pc_clr, pc_inc, pc_load, reg_addr, reg_we, wb_sel,
               alu_op, alu_a_load, alu_y_load, halted, illegal, bus_err
    );

    modport slave (
        output ir, rdata_zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, mdr_load, mdr_sel, ir_load,
               mar_load, pc_clr, pc_inc, pc_load, reg_addr, reg_we, wb_sel,
               alu_op, alu_a_load, alu_y_load, halted, illegal, bus_err
    );
endinterface

// File: rtl/control_seq_mem_wait_timer.sv
// mem_wait_timer: bus-timeout watchdog for one memory request.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (asserted on every state change)
//   active     : a memory request is outstanding this cycle
//   ready      : memory completes the request this cycle
//   expired    : this is the TIMEOUT-th waiting cycle and ready is low
// TIMEOUT = 0 disables the watchdog.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter; saturates so it can never wrap back under the limit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= '0;
        end else if (active && !ready && (count_r != CW'(TIMEOUT))) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    // count_r holds the cycles already waited, so TIMEOUT-1 marks the last one;
    // a ready in that same cycle still completes normally.
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = active && !ready && (count_r == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/control_seq.sv
// control_seq: multi-cycle fetch/decode/execute sequencer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : control_seq_if master -- instruction/flag inputs, memory
//                handshake, datapath strobes, halted/illegal/bus_err status
// The opcode sits in ir[WIDTH-1 -: OPW]; rd/rs are the two low REGADDR
// fields, so OPW + 2*REGADDR must not exceed WIDTH.
module control_seq
    import control_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OPW     = 4,
    parameter int REGADDR = 6,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    control_seq_if.master bus
);
    state_t             state_r, next_state_s;
    logic               rst_hold_r;
    logic               illegal_r, bus_err_r;
    logic               set_illegal_s, set_bus_err_s;
    logic               expired_s, mem_state_s, clear_s, taken_s;
    logic [OPW-1:0]     op_s;
    logic [REGADDR-1:0] rd_s, rs_s;

    assign op_s = bus.ir[WIDTH-1 -: OPW];
    assign rd_s = bus.ir[2*REGADDR-1:REGADDR];
    assign rs_s = bus.ir[REGADDR-1:0];

    // Decoded from the state alone so the watchdog does not loop through the FSM logic.
    assign mem_state_s = (state_r == FETCH) || (state_r == LD_MEM) ||
                         (state_r == ST_MEM) || (state_r == LI_MEM);
    assign clear_s     = (next_state_s != state_r);
    assign taken_s     = (op_s == OPW'(OP_JZ)) ? bus.rdata_zero : !bus.rdata_zero;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .active  (mem_state_s),
        .ready   (bus.mem_ready),
        .expired (expired_s)
    );

    // State register, reset-hold flag and sticky halt causes.
    // rst_hold_r keeps every output low for the first cycle after reset;
    // RST_PC then issues pc_clr on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RST_PC;
            rst_hold_r <= 1'b1;
            illegal_r  <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            rst_hold_r <= 1'b0;
            illegal_r  <= illegal_r | set_illegal_s;
            bus_err_r  <= bus_err_r | set_bus_err_s;
        end
    end

    assign bus.halted  = (state_r == HALT);
    assign bus.illegal = illegal_r;
    assign bus.bus_err = bus_err_r;

    // Next-state and strobe decode.
    always_comb begin
        next_state_s     = state_r;
        set_illegal_s    = 1'b0;
        set_bus_err_s    = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = ADDR_PC;
        bus.mdr_load     = 1'b0;
        bus.mdr_sel      = MDR_MEM;
        bus.ir_load      = 1'b0;
        bus.mar_load     = 1'b0;
        bus.pc_clr       = 1'b0;
        bus.pc_inc       = 1'b0;
        bus.pc_load      = 1'b0;
        bus.reg_addr     = '0;
        bus.reg_we       = 1'b0;
        bus.wb_sel       = WB_ALU;
        bus.alu_op       = 3'd0;
        bus.alu_a_load   = 1'b0;
        bus.alu_y_load   = 1'b0;
        case (state_r)
            RST_PC: begin
                if (rst_hold_r) begin
                    next_state_s = RST_PC;
                end else begin
                    bus.pc_clr   = 1'b1;
                    next_state_s = FETCH;
                end
            end
            FETCH, LD_MEM, ST_MEM, LI_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_we       = (state_r == ST_MEM);
                bus.mem_addr_sel = ((state_r == LD_MEM) || (state_r == ST_MEM)) ? ADDR_MAR : ADDR_PC;
                if (bus.mem_ready) begin
                    bus.ir_load  = (state_r == FETCH);
                    bus.mdr_load = (state_r == LD_MEM) || (state_r == LI_MEM);
                    if (state_r == FETCH) begin
                        next_state_s = DECODE;
                    end else if (state_r == LD_MEM) begin
                        next_state_s = LD_WB;
                    end else if (state_r == LI_MEM) begin
                        next_state_s = LI_WB;
                    end else begin
                        next_state_s = INCPC;
                    end
                end else if (expired_s) begin
                    next_state_s  = HALT;
                    set_bus_err_s = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            DECODE: begin
                if (op_s == OPW'(OP_SYS)) begin
                    next_state_s = HALT;
                end else if (op_s < OPW'(OP_LD)) begin
                    next_state_s = ALU_A;
                end else if (op_s == OPW'(OP_LD)) begin
                    next_state_s = LD_ADDR;
                end else if (op_s == OPW'(OP_ST)) begin
                    next_state_s = ST_ADDR;
                end else if (op_s == OPW'(OP_LI)) begin
                    next_state_s = LI_INC;
                end else if ((op_s == OPW'(OP_JZ)) || (op_s == OPW'(OP_JNZ))) begin
                    next_state_s = J_TEST;
                end else begin
                    next_state_s  = HALT;
                    set_illegal_s = 1'b1;
                end
            end
            ALU_A: begin
                bus.reg_addr   = rd_s;
                bus.alu_op     = op_s[2:0];
                bus.alu_a_load = 1'b1;
                next_state_s   = ALU_B;
            end
            ALU_B: begin
                bus.reg_addr   = rs_s;
                bus.alu_op     = op_s[2:0];
                bus.alu_y_load = 1'b1;
                next_state_s   = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_addr = rd_s;
                bus.alu_op   = op_s[2:0];
                bus.reg_we   = 1'b1;
                bus.wb_sel   = WB_ALU;
                next_state_s = INCPC;
            end
            LD_ADDR, ST_ADDR: begin
                bus.reg_addr = rs_s;
                bus.mar_load = 1'b1;
                next_state_s = (state_r == LD_ADDR) ? LD_MEM : ST_DATA;
            end
            ST_DATA: begin
                bus.reg_addr = rd_s;
                bus.mdr_load = 1'b1;
                bus.mdr_sel  = MDR_REG;
                next_state_s = ST_MEM;
            end
            LD_WB, LI_WB: begin
                bus.reg_addr = rd_s;
                bus.reg_we   = 1'b1;
                bus.wb_sel   = WB_MDR;
                next_state_s = INCPC;
            end
            LI_INC: begin
                bus.pc_inc   = 1'b1;
                next_state_s = LI_MEM;
            end
            J_TEST: begin
                bus.reg_addr = rs_s;
                next_state_s = taken_s ? J_LOAD : INCPC;
            end
            J_LOAD: begin
                bus.reg_addr = rd_s;
                bus.pc_load  = 1'b1;
                next_state_s = FETCH;
            end
            INCPC: begin
                bus.pc_inc   = 1'b1;
                next_state_s = FETCH;
            end
            HALT: begin
                next_state_s = HALT;
            end
            default: begin
                next_state_s = RST_PC;
            end
        endcase
    end

endmodule
